// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial shift link.
// State encodings and the link width common with the SIPO side.
package piso_serializer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int LINK_WIDTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, transmit side of the shift link.
// Takes a word on valid/ready and emits one qualified bit per clock.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             in_shift;
  logic             last_bit;
  logic             accept;
  logic             head_bit;

  assign in_shift = (state == ST_SHIFT);
  assign last_bit = in_shift & (bit_cnt == LAST);
  // Ready on the last bit lets words run back to back
  assign load_ready = ~in_shift | last_bit;
  assign accept     = load_valid & load_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign head_bit = shift_reg[WIDTH-1];
      assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head_bit = shift_reg[0];
      assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign serial_out   = in_shift & head_bit;
  assign serial_valid = in_shift;
  assign busy         = in_shift;
  assign frame_done   = last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      state     <= ST_SHIFT;
      bit_cnt   <= '0;
      shift_reg <= parallel_in;
    end else if (in_shift) begin
      shift_reg <= shifted;
      if (last_bit) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed scoreboard bench for piso_serializer.
// Covers MSB-first and LSB-first instances plus a SIPO loopback model.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] parallel_in;
  logic       load_valid;
  logic       load_ready;
  logic       serial_out;
  logic       serial_valid;
  logic       frame_done;
  logic       busy;

  logic [3:0] lsb_in;
  logic       lsb_valid;
  logic       lsb_ready;
  logic       lsb_out;
  logic       lsb_sv;
  logic       lsb_fd;
  logic       lsb_busy;

  logic [3:0] sipo;

  int n_checks = 0;
  int n_fail   = 0;

  logic sb[$];
  logic lsb_q[$];

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .parallel_in  (parallel_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .reset        (reset),
    .parallel_in  (lsb_in),
    .load_valid   (lsb_valid),
    .load_ready   (lsb_ready),
    .serial_out   (lsb_out),
    .serial_valid (lsb_sv),
    .frame_done   (lsb_fd),
    .busy         (lsb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SIPO receiver: shift-left, new bit enters at bit 0
  always @(posedge clk) begin
    if (reset) sipo <= '0;
    else if (serial_valid) sipo <= {sipo[2:0], serial_out};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_msb(logic [3:0] w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[i]);
  endtask

  task automatic exp_cycle(string tag, logic v, logic fd, logic rdy);
    logic b;
    chk($sformatf("%s_valid", tag), {7'd0, serial_valid}, {7'd0, v});
    chk($sformatf("%s_busy", tag), {7'd0, busy}, {7'd0, v});
    chk($sformatf("%s_done", tag), {7'd0, frame_done}, {7'd0, fd});
    chk($sformatf("%s_ready", tag), {7'd0, load_ready}, {7'd0, rdy});
    if (v) begin
      chk($sformatf("%s_sb_nonempty", tag), {7'd0, sb.size() > 0}, 8'd1);
      if (sb.size() > 0) begin
        b = sb.pop_front();
        chk($sformatf("%s_bit", tag), {7'd0, serial_out}, {7'd0, b});
      end
    end else begin
      chk($sformatf("%s_idle_out", tag), {7'd0, serial_out}, 8'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    load_valid  = 1'b0;
    parallel_in = 4'b0000;
    lsb_valid   = 1'b0;
    lsb_in      = 4'b0000;

    // reset held two cycles
    tick();
    tick();
    exp_cycle("rst", 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk("rst_release_ready", {7'd0, load_ready}, 8'd1);
    chk("rst_lsb_ready", {7'd0, lsb_ready}, 8'd1);
    tick();
    exp_cycle("idle", 1'b0, 1'b0, 1'b1);

    // single word 1011
    parallel_in = 4'b1011;
    load_valid  = 1'b1;
    push_msb(4'b1011);
    tick();
    load_valid  = 1'b0;
    parallel_in = 4'b0101;
    for (int i = 1; i <= 4; i++) begin
      exp_cycle($sformatf("single_c%0d", i), 1'b1, i == 4, i == 4);
      tick();
    end
    exp_cycle("single_c5", 1'b0, 1'b0, 1'b1);
    chk("single_sb_drained", 8'(sb.size()), 8'd0);

    // back-to-back 1011 then 0110 with load_valid held
    parallel_in = 4'b1011;
    load_valid  = 1'b1;
    push_msb(4'b1011);
    push_msb(4'b0110);
    tick();
    parallel_in = 4'b0110;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) load_valid = 1'b0;
      exp_cycle($sformatf("b2b_c%0d", i), 1'b1,
                (i == 4) || (i == 8), (i == 4) || (i == 8));
      tick();
    end
    exp_cycle("b2b_c9", 1'b0, 1'b0, 1'b1);

    // load offered early during a 0000 frame
    parallel_in = 4'b0000;
    load_valid  = 1'b1;
    push_msb(4'b0000);
    push_msb(4'b1111);
    tick();
    parallel_in = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) load_valid = 1'b0;
      exp_cycle($sformatf("hold_c%0d", i), 1'b1,
                (i == 4) || (i == 8), (i == 4) || (i == 8));
      tick();
    end
    exp_cycle("hold_c9", 1'b0, 1'b0, 1'b1);
    chk("hold_sb_drained", 8'(sb.size()), 8'd0);

    // reset during bit 2 of 1010, with a load offered at that edge
    parallel_in = 4'b1010;
    load_valid  = 1'b1;
    push_msb(4'b1010);
    tick();
    load_valid = 1'b0;
    exp_cycle("abort_c1", 1'b1, 1'b0, 1'b0);
    tick();
    exp_cycle("abort_c2", 1'b1, 1'b0, 1'b0);
    reset       = 1'b1;
    load_valid  = 1'b1;
    parallel_in = 4'b1111;
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    sb.delete();
    exp_cycle("abort_c3", 1'b0, 1'b0, 1'b1);
    tick();
    exp_cycle("abort_c4", 1'b0, 1'b0, 1'b1);

    // loopback into SIPO with 1101
    parallel_in = 4'b1101;
    load_valid  = 1'b1;
    push_msb(4'b1101);
    tick();
    load_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_cycle($sformatf("loop_c%0d", i), 1'b1, i == 4, i == 4);
      tick();
    end
    chk("loop_sipo", {4'd0, sipo}, 8'h0D);

    // LSB-first instance, word 1101 -> 1,0,1,1
    lsb_in    = 4'b1101;
    lsb_valid = 1'b1;
    for (int i = 0; i < 4; i++) lsb_q.push_back(lsb_in[i]);
    tick();
    lsb_valid = 1'b0;
    lsb_in    = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("lsb_valid_c%0d", i), {7'd0, lsb_sv}, 8'd1);
      chk($sformatf("lsb_done_c%0d", i), {7'd0, lsb_fd}, {7'd0, i == 4});
      if (lsb_q.size() > 0)
        chk($sformatf("lsb_bit_c%0d", i), {7'd0, lsb_out},
            {7'd0, lsb_q.pop_front()});
      tick();
    end
    chk("lsb_idle_valid", {7'd0, lsb_sv}, 8'd0);
    chk("lsb_idle_busy", {7'd0, lsb_busy}, 8'd0);
    chk("lsb_sb_drained", 8'(lsb_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
